mc_controller: RTL and testbench



---
 rtl/mc_controller_if.sv | 45 ++++
 rtl/mc_controller.sv | 238 +++++++++++++++++++++++
 tb/tb_mc_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface mc_controller_if #(
    parameter int unsigned ALUCTRL_W = 2
);
    localparam int unsigned COND_W  = 4;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned RD_W    = 4;
    localparam int unsigned NZCV_W  = 4;
    localparam int unsigned SEL_W   = 2;

    // Latched instruction fields and live ALU flags
    logic [COND_W-1:0]    Cond;
    logic [OP_W-1:0]      Op;
    logic [FUNCT_W-1:0]   Funct;
    logic [RD_W-1:0]      Rd;
    logic [NZCV_W-1:0]    ALUFlags;

    // Enables and mux selects towards the datapath
    logic                 PCWrite;
    logic                 MemWrite;
    logic                 RegWrite;
    logic                 IRWrite;
    logic                 AdrSrc;
    logic [SEL_W-1:0]     RegSrc;
    logic [SEL_W-1:0]     ALUSrcA;
    logic [SEL_W-1:0]     ALUSrcB;
    logic [SEL_W-1:0]     ResultSrc;
    logic [SEL_W-1:0]     ImmSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 Undef;

    modport master (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
               RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Undef
    );

    modport slave (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
               RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Undef
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: sequencing FSM, ALU decoder, condition check and NZCV storage.
// Define MC_CTRL_CMP_EN to decode CMP (SUB that updates flags without register writeback).
module mc_controller #(
    parameter int unsigned ALUCTRL_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);
    localparam int unsigned NZCV_W = 4;
    localparam int unsigned ALU_W  = 3;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH,
        UNKNOWN
    } state_e;

    state_e              state_q;
    state_e              state_d;
    state_e              cur_state;
    logic [NZCV_W-1:0]   flags_q;
    logic [NZCV_W-1:0]   flags_d;
    logic                cond_ex_dly_q;

    logic                cond_ex;
    logic                next_pc;
    logic                branch;
    logic                reg_w;
    logic                mem_w;
    logic                ir_write;
    logic                alu_op;
    logic                undef;
    logic                adr_src;
    logic [1:0]          alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          result_src;
    logic [ALU_W-1:0]    alu_ctrl;
    logic [1:0]          flag_w;
    logic                no_write;
    logic                pcs;

    // While reset is held the selects present FETCH values.
    assign cur_state = reset ? FETCH : state_q;

    // Main FSM: next state plus per-state enables and selects
    always_comb begin
        state_d    = FETCH;
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        ir_write   = 1'b0;
        alu_op     = 1'b0;
        undef      = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        case (cur_state)
            FETCH: begin
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                state_d    = DECODE;
            end
            DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (bus.Op)
                    2'b00:   state_d = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = UNKNOWN;
                endcase
            end
            MEMADR: begin
                alu_src_b = 2'b01;
                state_d   = bus.Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            EXECUTER: begin
                alu_op  = 1'b1;
                state_d = ALUWB;
            end
            EXECUTEI: begin
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_w = ~no_write;
            end
            BRANCH: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            UNKNOWN: begin
                undef = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // ALU decoder; NoWrite is held for the whole instruction so ALUWB can see it
    always_comb begin
        alu_ctrl = '0;
        flag_w   = 2'b00;
        no_write = 1'b0;
`ifdef MC_CTRL_CMP_EN
        no_write = (bus.Op == 2'b00) && (bus.Funct[4:1] == 4'b1010);
`endif
        if (alu_op) begin
            case (bus.Funct[4:1])
                4'b0100: begin
                    alu_ctrl = ALU_W'(0);
                    flag_w   = {bus.Funct[0], bus.Funct[0]};
                end
                4'b0010: begin
                    alu_ctrl = ALU_W'(1);
                    flag_w   = {bus.Funct[0], bus.Funct[0]};
                end
                4'b0000: begin
                    alu_ctrl = ALU_W'(2);
                    flag_w   = {bus.Funct[0], 1'b0};
                end
                4'b1100: begin
                    alu_ctrl = ALU_W'(3);
                    flag_w   = {bus.Funct[0], 1'b0};
                end
                4'b0001: begin
                    if (ALUCTRL_W >= 32'd3) begin
                        alu_ctrl = ALU_W'(4);
                        flag_w   = {bus.Funct[0], 1'b0};
                    end
                end
`ifdef MC_CTRL_CMP_EN
                4'b1010: begin
                    alu_ctrl = ALU_W'(1);
                    flag_w   = {bus.Funct[0], bus.Funct[0]};
                end
`endif
                default: begin
                    alu_ctrl = '0;
                    flag_w   = 2'b00;
                end
            endcase
        end
    end

    // Condition evaluation against the stored NZCV
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags_q;
        case (bus.Cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~(c & ~z);
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (flag_w[1] && cond_ex) begin
            flags_d[3:2] = bus.ALUFlags[3:2];
        end
        if (flag_w[0] && cond_ex) begin
            flags_d[1:0] = bus.ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            flags_q       <= '0;
            cond_ex_dly_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flags_q       <= flags_d;
            cond_ex_dly_q <= cond_ex;
        end
    end

    // Writes are qualified by the condition captured one cycle earlier
    assign pcs = ((bus.Rd == 4'hF) & reg_w) | branch;

    assign bus.PCWrite    = ~reset & ((pcs & cond_ex_dly_q) | next_pc);
    assign bus.RegWrite   = ~reset & reg_w & cond_ex_dly_q;
    assign bus.MemWrite   = ~reset & mem_w & cond_ex_dly_q;
    assign bus.IRWrite    = ~reset & ir_write;
    assign bus.Undef      = ~reset & undef;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.ImmSrc     = bus.Op;
    assign bus.ALUControl = ALUCTRL_W'(alu_ctrl);
endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class cycle by cycle.
module tb_mc_controller;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mc_controller_if #(.ALUCTRL_W(2)) bus ();
    mc_controller_if #(.ALUCTRL_W(3)) bus3 ();

    mc_controller #(.ALUCTRL_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    mc_controller #(.ALUCTRL_W(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.master)
    );

    assign bus3.Cond     = bus.Cond;
    assign bus3.Op       = bus.Op;
    assign bus3.Funct    = bus.Funct;
    assign bus3.Rd       = bus.Rd;
    assign bus3.ALUFlags = bus.ALUFlags;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}
    localparam logic [6:0] SEL_FD  = 7'b0_01_10_10;
    localparam logic [6:0] SEL_MA  = 7'b0_00_01_00;
    localparam logic [6:0] SEL_MR  = 7'b1_00_00_00;
    localparam logic [6:0] SEL_MWB = 7'b0_00_00_01;
    localparam logic [6:0] SEL_EI  = 7'b0_00_01_00;
    localparam logic [6:0] SEL_Z   = 7'b0_00_00_00;
    localparam logic [6:0] SEL_BR  = 7'b0_10_01_10;
    // {PCWrite, MemWrite, RegWrite, IRWrite, Undef}
    localparam logic [4:0] WE_F    = 5'b10010;
    localparam logic [4:0] WE_0    = 5'b00000;
    localparam logic [4:0] WE_RW   = 5'b00100;
    localparam logic [4:0] WE_MW   = 5'b01000;
    localparam logic [4:0] WE_PC   = 5'b10000;
    localparam logic [4:0] WE_PCRW = 5'b10100;
    localparam logic [4:0] WE_UD   = 5'b00001;

    logic [6:0] sel_o;
    logic [4:0] we_o;
    assign sel_o = {bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc};
    assign we_o  = {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.Undef};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check one state cycle, then advance to just after the next rising edge
    task automatic cyc(input string tag, input logic [6:0] sel_e, input logic [4:0] we_e,
                       input logic [2:0] alu_e);
        #1;
        chk({tag, ".sel"}, 32'(sel_o), 32'(sel_e));
        chk({tag, ".we"}, 32'(we_o), 32'(we_e));
        chk({tag, ".alu"}, 32'(bus.ALUControl), 32'(alu_e));
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                         input logic [3:0] rd, input logic [3:0] nzcv);
        bus.Cond     = cond;
        bus.Op       = op;
        bus.Funct    = funct;
        bus.Rd       = rd;
        bus.ALUFlags = nzcv;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        instr(4'hE, 2'b00, 6'b001000, 4'd2, 4'b0000);
        #1;
        cyc("rst0", SEL_FD, WE_0, 3'd0);
        cyc("rst1", SEL_FD, WE_0, 3'd0);
        reset = 1'b0;

        // ADD r2 (register), AL
        cyc("add.F", SEL_FD, WE_F, 3'd0);
        chk("add.regsrc", 32'(bus.RegSrc), 32'd0);
        cyc("add.D", SEL_FD, WE_0, 3'd0);
        cyc("add.ER", SEL_Z, WE_0, 3'd0);
        cyc("add.WB", SEL_Z, WE_RW, 3'd0);

        // LDR
        instr(4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000);
        cyc("ldr.F", SEL_FD, WE_F, 3'd0);
        chk("ldr.regsrc", 32'(bus.RegSrc), 32'd2);
        chk("ldr.immsrc", 32'(bus.ImmSrc), 32'd1);
        cyc("ldr.D", SEL_FD, WE_0, 3'd0);
        cyc("ldr.MA", SEL_MA, WE_0, 3'd0);
        cyc("ldr.MR", SEL_MR, WE_0, 3'd0);
        cyc("ldr.MWB", SEL_MWB, WE_RW, 3'd0);

        // STR
        instr(4'hE, 2'b01, 6'b011000, 4'd3, 4'b0000);
        cyc("str.F", SEL_FD, WE_F, 3'd0);
        cyc("str.D", SEL_FD, WE_0, 3'd0);
        cyc("str.MA", SEL_MA, WE_0, 3'd0);
        cyc("str.MW", SEL_MR, WE_MW, 3'd0);

        // SUBS with Z=1 from the ALU
        instr(4'hE, 2'b00, 6'b000101, 4'd4, 4'b0100);
        cyc("subs.F", SEL_FD, WE_F, 3'd0);
        cyc("subs.D", SEL_FD, WE_0, 3'd0);
        cyc("subs.ER", SEL_Z, WE_0, 3'd1);
        cyc("subs.WB", SEL_Z, WE_RW, 3'd0);

        // BEQ taken, then BNE not taken
        instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000);
        cyc("beq.F", SEL_FD, WE_F, 3'd0);
        chk("beq.regsrc", 32'(bus.RegSrc), 32'd1);
        chk("beq.immsrc", 32'(bus.ImmSrc), 32'd2);
        cyc("beq.D", SEL_FD, WE_0, 3'd0);
        cyc("beq.BR", SEL_BR, WE_PC, 3'd0);
        instr(4'h1, 2'b10, 6'b100000, 4'd0, 4'b0000);
        cyc("bne.F", SEL_FD, WE_F, 3'd0);
        cyc("bne.D", SEL_FD, WE_0, 3'd0);
        cyc("bne.BR", SEL_BR, WE_0, 3'd0);

        // ADD to PC, AL
        instr(4'hE, 2'b00, 6'b001000, 4'hF, 4'b0000);
        cyc("addpc.F", SEL_FD, WE_F, 3'd0);
        cyc("addpc.D", SEL_FD, WE_0, 3'd0);
        cyc("addpc.ER", SEL_Z, WE_0, 3'd0);
        cyc("addpc.WB", SEL_Z, WE_PCRW, 3'd0);

        // ORRS immediate clears Z
        instr(4'hE, 2'b00, 6'b111001, 4'd5, 4'b0000);
        cyc("orr.F", SEL_FD, WE_F, 3'd0);
        cyc("orr.D", SEL_FD, WE_0, 3'd0);
        cyc("orr.EI", SEL_EI, WE_0, 3'd3);
        cyc("orr.WB", SEL_Z, WE_RW, 3'd0);

        // ADDSEQ with Z=0: no writeback, flags must not load
        instr(4'h0, 2'b00, 6'b001001, 4'd6, 4'b0100);
        cyc("addeq.F", SEL_FD, WE_F, 3'd0);
        cyc("addeq.D", SEL_FD, WE_0, 3'd0);
        cyc("addeq.ER", SEL_Z, WE_0, 3'd0);
        cyc("addeq.WB", SEL_Z, WE_0, 3'd0);
        instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000);
        cyc("beq2.F", SEL_FD, WE_F, 3'd0);
        cyc("beq2.D", SEL_FD, WE_0, 3'd0);
        cyc("beq2.BR", SEL_BR, WE_0, 3'd0);

        // AND reg, then EOR reg on both ALU widths
        instr(4'hE, 2'b00, 6'b000000, 4'd7, 4'b0000);
        cyc("and.F", SEL_FD, WE_F, 3'd0);
        cyc("and.D", SEL_FD, WE_0, 3'd0);
        cyc("and.ER", SEL_Z, WE_0, 3'd2);
        cyc("and.WB", SEL_Z, WE_RW, 3'd0);
        instr(4'hE, 2'b00, 6'b000010, 4'd7, 4'b0000);
        cyc("eor.F", SEL_FD, WE_F, 3'd0);
        cyc("eor.D", SEL_FD, WE_0, 3'd0);
        chk("eor.w3", 32'(bus3.ALUControl), 32'd4);
        cyc("eor.ER", SEL_Z, WE_0, 3'd0);
        cyc("eor.WB", SEL_Z, WE_RW, 3'd0);

        // Unimplemented Op=11
        instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000);
        cyc("undef.F", SEL_FD, WE_F, 3'd0);
        cyc("undef.D", SEL_FD, WE_0, 3'd0);
        cyc("undef.U", SEL_Z, WE_UD, 3'd0);
        cyc("undef.F2", SEL_FD, WE_F, 3'd0);
        cyc("undef.D2", SEL_FD, WE_0, 3'd0);
        cyc("undef.U2", SEL_Z, WE_UD, 3'd0);

        // CMP with S=1 and ALU reporting Z=1; BEQ then reveals whether flags loaded
        instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100);
        cyc("cmp.F", SEL_FD, WE_F, 3'd0);
        cyc("cmp.D", SEL_FD, WE_0, 3'd0);
`ifdef MC_CTRL_CMP_EN
        cyc("cmp.ER", SEL_Z, WE_0, 3'd1);
        cyc("cmp.WB", SEL_Z, WE_0, 3'd0);
`else
        cyc("cmp.ER", SEL_Z, WE_0, 3'd0);
        cyc("cmp.WB", SEL_Z, WE_RW, 3'd0);
`endif
        instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000);
        cyc("beq3.F", SEL_FD, WE_F, 3'd0);
        cyc("beq3.D", SEL_FD, WE_0, 3'd0);
`ifdef MC_CTRL_CMP_EN
        cyc("beq3.BR", SEL_BR, WE_PC, 3'd0);
`else
        cyc("beq3.BR", SEL_BR, WE_0, 3'd0);
`endif

        // Reset asserted while a STR sits in MEMADR
        instr(4'hE, 2'b01, 6'b011000, 4'd3, 4'b0000);
        cyc("rstmid.F", SEL_FD, WE_F, 3'd0);
        cyc("rstmid.D", SEL_FD, WE_0, 3'd0);
        reset = 1'b1;
        cyc("rstmid.R", SEL_FD, WE_0, 3'd0);
        reset = 1'b0;
        cyc("rstmid.F2", SEL_FD, WE_F, 3'd0);
        cyc("rstmid.D2", SEL_FD, WE_0, 3'd0);
        cyc("rstmid.MA", SEL_MA, WE_0, 3'd0);
        cyc("rstmid.MW", SEL_MR, WE_MW, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
